// File: rtl/caravel.sv
// SoC stand-in: boots from SPI flash and runs a 2-byte command stream that drives
// checkbits, a 4x8 leaky integrate-and-fire layer and an 8N1 UART transmitter.
module caravel #(
  parameter int CLK_DIV  = 2,
  parameter int UART_DIV = 434
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  input  logic       flash_io1,
  inout  wire [37:0] mprj_io,
  output logic       gpio
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam int UW = $clog2(UART_DIV) + 1;

  typedef enum logic [2:0] {S_BOOT, S_XFER, S_EXEC, S_UART, S_HALT} state_t;
  state_t state;

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    hdr_left;
  logic [31:0]   tx_sr;
  logic [7:0]    rx_sr;
  logic          have_op;
  logic [7:0]    opcode;
  logic [7:0]    arg;

  logic [15:0]   checkbits;
  logic [3:0]    spike;
  logic          uart_tx;
  logic [9:0]    uart_sr;
  logic [3:0]    uart_bits;
  logic [UW-1:0] baud;

  logic signed [7:0]  w [4][8];
  logic signed [15:0] v [4];
  logic [7:0]         cnt [4];
  logic [7:0]         threshold;
  logic [3:0]         leak;
  logic [4:0]         ptr;

  logic signed [17:0] acc [4];
  logic signed [15:0] v_next [4];
  logic [3:0]         fire;

  assign mprj_io = {2'bz, spike, checkbits, 9'bz, uart_tx, 6'bz};

  // 18-bit accumulator holds leak term plus eight weights without overflow before saturation
  always_comb begin
    for (int unsigned n = 0; n < 4; n++) begin
      acc[n] = 18'(v[n]) - 18'(v[n] >>> leak);
      for (int unsigned i = 0; i < 8; i++) begin
        if (arg[i]) acc[n] = acc[n] + 18'(w[n][i]);
      end
      if (acc[n] > 18'sd32767)       v_next[n] = 16'sh7fff;
      else if (acc[n] < -18'sd32768) v_next[n] = 16'sh8000;
      else                           v_next[n] = acc[n][15:0];
      fire[n] = (v_next[n] >= $signed({8'h00, threshold}));
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_BOOT;
      flash_csb <= 1'b1;
      flash_clk <= 1'b0;
      flash_io0 <= 1'b0;
      gpio      <= 1'b0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      hdr_left  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      have_op   <= 1'b0;
      opcode    <= '0;
      arg       <= '0;
      checkbits <= '0;
      spike     <= '0;
      uart_tx   <= 1'b1;
      uart_sr   <= '1;
      uart_bits <= '0;
      baud      <= '0;
      threshold <= 8'h40;
      leak      <= 4'd4;
      ptr       <= '0;
      for (int unsigned n = 0; n < 4; n++) begin
        v[n]   <= '0;
        cnt[n] <= '0;
        for (int unsigned i = 0; i < 8; i++) w[n][i] <= '0;
      end
    end else begin
      unique case (state)
        S_BOOT: begin
          flash_csb <= 1'b0;
          flash_io0 <= 1'b0;
          tx_sr     <= 32'h0300_0000;
          hdr_left  <= 3'd4;
          bit_cnt   <= '0;
          div_cnt   <= '0;
          have_op   <= 1'b0;
          state     <= S_XFER;
        end
        S_XFER: begin
          if (div_cnt != DW'(CLK_DIV - 1)) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!flash_clk) begin
              flash_clk <= 1'b1;
              rx_sr     <= {rx_sr[6:0], flash_io1};
              bit_cnt   <= bit_cnt + 3'd1;
            end else begin
              flash_clk <= 1'b0;
              tx_sr     <= {tx_sr[30:0], 1'b0};
              flash_io0 <= tx_sr[30];
              // bit_cnt wraps to 0 after the 8th rising edge, so this falling edge closes a byte
              if (bit_cnt == 3'd0) begin
                if (hdr_left != 3'd0) begin
                  hdr_left <= hdr_left - 3'd1;
                end else if (!have_op) begin
                  opcode  <= rx_sr;
                  have_op <= 1'b1;
                end else begin
                  arg     <= rx_sr;
                  have_op <= 1'b0;
                  state   <= S_EXEC;
                end
              end
            end
          end
        end
        S_EXEC: begin
          state <= S_XFER;
          case (opcode)
            8'h00: begin
              flash_csb <= 1'b1;
              gpio      <= 1'b1;
              state     <= S_HALT;
            end
            8'h01: checkbits[15:8] <= arg;
            8'h02: checkbits[7:0]  <= arg;
            8'h03: begin
              spike <= fire;
              for (int unsigned n = 0; n < 4; n++) begin
                if (fire[n]) begin
                  v[n] <= '0;
                  if (cnt[n] != 8'hff) cnt[n] <= cnt[n] + 8'd1;
                end else begin
                  v[n] <= v_next[n];
                end
              end
            end
            8'h04: ptr <= arg[4:0];
            8'h05: begin
              w[ptr[4:3]][ptr[2:0]] <= arg;
              ptr <= ptr + 5'd1;
            end
            8'h06: threshold <= arg;
            8'h07: leak <= arg[3:0];
            8'h08: begin
              spike <= '0;
              for (int unsigned n = 0; n < 4; n++) begin
                v[n]   <= '0;
                cnt[n] <= '0;
              end
            end
            8'h09: checkbits[7:0] <= cnt[arg[1:0]];
            8'h0a: begin
              uart_sr   <= {1'b1, arg, 1'b0};
              uart_tx   <= 1'b0;
              uart_bits <= 4'd9;
              baud      <= UW'(UART_DIV - 1);
              state     <= S_UART;
            end
            default: ;
          endcase
        end
        S_UART: begin
          if (baud != '0) begin
            baud <= baud - 1'b1;
          end else if (uart_bits == 4'd0) begin
            state <= S_XFER;
          end else begin
            uart_sr   <= {1'b1, uart_sr[9:1]};
            uart_tx   <= uart_sr[1];
            uart_bits <= uart_bits - 4'd1;
            baud      <= UW'(UART_DIV - 1);
          end
        end
        S_HALT: ;
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_caravel.sv
// Bench for caravel: SPI flash image model, command-level reference model, UART frame sampling.
module tb_caravel;
  localparam int CLK_DIV  = 2;
  localparam int UART_DIV = 8;
  localparam int IMG      = 2048;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flash_csb, flash_clk, flash_io0;
  logic       flash_io1 = 1'b0;
  logic       gpio;
  wire [37:0] mprj_io;

  logic [15:0] cb;
  logic [3:0]  spk;
  logic        txd;
  assign cb  = mprj_io[31:16];
  assign spk = mprj_io[35:32];
  assign txd = mprj_io[6];

  caravel #(.CLK_DIV(CLK_DIV), .UART_DIV(UART_DIV)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .flash_csb(flash_csb),
    .flash_clk(flash_clk),
    .flash_io0(flash_io0),
    .flash_io1(flash_io1),
    .mprj_io  (mprj_io),
    .gpio     (gpio)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // flash memory and a mode-0 SPI READ responder
  logic [7:0]  img [IMG];
  logic [31:0] cmd = '0;
  logic        pclk = 1'b0;
  int          bitn = 0;
  int          rise_n = 0;
  int          rise_cyc [2];
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (flash_csb) begin
      bitn   = 0;
      rise_n = 0;
    end else if (flash_clk && !pclk) begin
      if (bitn < 32) cmd = {cmd[30:0], flash_io0};
      if (rise_n < 2) rise_cyc[rise_n] = cyc;
      rise_n++;
      bitn++;
    end else if (!flash_clk && pclk && bitn >= 32) begin
      int k;
      logic [7:0] b;
      k = bitn - 32;
      b = img[(k / 8) % IMG];
      flash_io1 = b[7 - (k % 8)];
    end
    pclk = flash_clk;
  end

  // history of checkbits values seen after reset release
  logic [15:0] cbq [$];
  logic [15:0] pcb = '0;
  always @(negedge clk) begin
    if (cb !== pcb) begin
      cbq.push_back(cb);
      pcb = cb;
    end
  end

  function automatic int fdiv(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  // command-level interpretation of a flash image
  task automatic model(input logic [7:0] p[$], output logic [15:0] ecb, output logic [3:0] espk);
    int wt [32];
    int vm [4];
    int cn [4];
    int thr, lk, pt, a;
    thr = 64; lk = 4; pt = 0;
    ecb = '0; espk = '0;
    for (int i = 0; i < 32; i++) wt[i] = 0;
    for (int n = 0; n < 4; n++) begin vm[n] = 0; cn[n] = 0; end
    for (a = 0; a + 1 < p.size(); a += 2) begin
      logic [7:0] op, ar;
      op = p[a]; ar = p[a + 1];
      if (op == 8'h00) break;
      case (op)
        8'h01: ecb[15:8] = ar;
        8'h02: ecb[7:0] = ar;
        8'h03: for (int n = 0; n < 4; n++) begin
          int s;
          s = vm[n] - fdiv(vm[n], 1 << lk);
          for (int i = 0; i < 8; i++) if (ar[i]) s += wt[n * 8 + i];
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
          if (s >= thr) begin
            espk[n] = 1'b1; vm[n] = 0;
            if (cn[n] < 255) cn[n]++;
          end else begin
            espk[n] = 1'b0; vm[n] = s;
          end
        end
        8'h04: pt = int'(ar) % 32;
        8'h05: begin
          wt[pt] = (ar >= 128) ? int'(ar) - 256 : int'(ar);
          pt = (pt + 1) % 32;
        end
        8'h06: thr = int'(ar);
        8'h07: lk = int'(ar) % 16;
        8'h08: begin
          espk = '0;
          for (int n = 0; n < 4; n++) begin vm[n] = 0; cn[n] = 0; end
        end
        8'h09: ecb[7:0] = 8'(cn[int'(ar) % 4]);
        default: ;
      endcase
    end
  endtask

  task automatic gen(output logic [7:0] p[$]);
    int n;
    p = {};
    n = 20 + int'($urandom_range(0, 14));
    for (int k = 0; k < n; k++) begin
      int r;
      logic [7:0] op;
      r = int'($urandom_range(0, 99));
      if      (r < 10) op = 8'h01;
      else if (r < 20) op = 8'h02;
      else if (r < 38) op = 8'h03;
      else if (r < 46) op = 8'h04;
      else if (r < 62) op = 8'h05;
      else if (r < 68) op = 8'h06;
      else if (r < 73) op = 8'h07;
      else if (r < 76) op = 8'h08;
      else if (r < 90) op = 8'h09;
      else if (r < 93) op = 8'h0a;
      else             op = 8'($urandom_range(11, 255));
      p.push_back(op);
      p.push_back(8'($urandom));
    end
    p.push_back(8'h00);
    p.push_back(8'h00);
  endtask

  task automatic start(input logic [7:0] p[$]);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < IMG; i++) img[i] = 8'h00;
    for (int i = 0; i < p.size(); i++) img[i] = p[i];
    cbq.delete();
    rst = 1'b0;
  endtask

  task automatic wait_halt(input int maxc);
    int i;
    i = 0;
    while (!gpio && i < maxc) begin
      @(negedge clk);
      i++;
    end
    chk("halt_reached", 32'(gpio), 32'd1);
  endtask

  task automatic wait_tx_low(input string tag);
    int i;
    i = 0;
    while (txd && i < 4000) begin
      @(negedge clk);
      i++;
    end
    chk(tag, 32'(txd), 32'd0);
  endtask

  initial begin
    logic [7:0]  p [$];
    logic [15:0] ecb, exp_seq [4];
    logic [3:0]  espk;
    logic [9:0]  frame;
    int          lowc;

    // reset held for 5 cycles
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_csb", 32'(flash_csb), 32'd1);
    chk("rst_fclk", 32'(flash_clk), 32'd0);
    chk("rst_io0", 32'(flash_io0), 32'd0);
    chk("rst_checkbits", 32'(cb), 32'h0000);
    chk("rst_spike", 32'(spk), 32'h0);
    chk("rst_uart_tx", 32'(txd), 32'd1);
    chk("rst_gpio", 32'(gpio), 32'd0);

    // checkbits sequence plus boot framing
    p = '{8'h01, 8'hAB, 8'h02, 8'h40, 8'h02, 8'h41, 8'h02, 8'h51, 8'h00, 8'h00};
    start(p);
    @(negedge clk);
    chk("boot_csb_low", 32'(flash_csb), 32'd0);
    wait_halt(2000);
    chk("boot_cmd", cmd, 32'h0300_0000);
    chk("boot_sclk_period", 32'(rise_cyc[1] - rise_cyc[0]), 32'd4);
    exp_seq = '{16'hAB00, 16'hAB40, 16'hAB41, 16'hAB51};
    chk("chk_seq_len", 32'(cbq.size()), 32'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("chk_seq%0d", k), 32'((k < cbq.size()) ? cbq[k] : 16'hDEAD), 32'(exp_seq[k]));
    chk("halt_csb", 32'(flash_csb), 32'd1);
    chk("halt_fclk", 32'(flash_clk), 32'd0);

    // one timestep only: v0=48 stays below 64
    p = '{8'h04, 8'h00, 8'h05, 8'h30, 8'h07, 8'h0F, 8'h03, 8'h01, 8'h09, 8'h00, 8'h00, 8'h00};
    start(p);
    wait_halt(2000);
    chk("step1_spike", 32'(spk), 32'h0);
    chk("step1_count", 32'(cb), 32'h0000);

    // two timesteps: v0 reaches 96 and fires
    p = '{8'h04, 8'h00, 8'h05, 8'h30, 8'h07, 8'h0F, 8'h03, 8'h01, 8'h03, 8'h01,
          8'h09, 8'h00, 8'h00, 8'h00};
    start(p);
    wait_halt(2000);
    chk("step2_spike", 32'(spk), 32'h1);
    chk("step2_count", 32'(cb[7:0]), 32'h01);

    // negative saturation: 300 steps of -128, then 260 steps of +127 from the clamp
    p = '{8'h04, 8'h00, 8'h05, 8'h80, 8'h07, 8'h0F};
    for (int k = 0; k < 300; k++) begin p.push_back(8'h03); p.push_back(8'h01); end
    p.push_back(8'h09); p.push_back(8'h00);
    p.push_back(8'h04); p.push_back(8'h00);
    p.push_back(8'h05); p.push_back(8'h7F);
    for (int k = 0; k < 260; k++) begin p.push_back(8'h03); p.push_back(8'h01); end
    p.push_back(8'h09); p.push_back(8'h00);
    p.push_back(8'h00); p.push_back(8'h00);
    start(p);
    wait_halt(45000);
    chk("clamp_first_report", 32'(cbq.size()), 32'd1);
    chk("clamp_final_count", 32'(cb[7:0]), 32'h04);

    // UART: start bit width, then reset mid-frame
    p = '{8'h0A, 8'h55, 8'h00, 8'h00};
    start(p);
    wait_tx_low("uart_start_a");
    lowc = 0;
    while (!txd && lowc < 4 * UART_DIV) begin
      lowc++;
      @(negedge clk);
    end
    chk("uart_start_len", 32'(lowc), 32'(UART_DIV));
    repeat (UART_DIV) @(negedge clk);
    chk("uart_bit1", 32'(txd), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("uart_abort_tx", 32'(txd), 32'd1);
    chk("uart_abort_csb", 32'(flash_csb), 32'd1);

    // UART: full frame sampled mid-bit
    start(p);
    wait_tx_low("uart_start_b");
    repeat (UART_DIV / 2) @(negedge clk);
    frame[0] = txd;
    for (int j = 1; j < 10; j++) begin
      repeat (UART_DIV) @(negedge clk);
      frame[j] = txd;
    end
    chk("uart_stall", 32'(gpio), 32'd0);
    chk("uart_frame", 32'(frame), 32'({1'b1, 8'h55, 1'b0}));
    wait_halt(2000);

    // randomized command streams against the reference model
    for (int t = 0; t < 4; t++) begin
      gen(p);
      model(p, ecb, espk);
      if (t == 0) begin
        start(p);
        repeat (150) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midxfer_csb", 32'(flash_csb), 32'd1);
        chk("midxfer_fclk", 32'(flash_clk), 32'd0);
        chk("midxfer_io0", 32'(flash_io0), 32'd0);
        chk("midxfer_cb", 32'(cb), 32'h0000);
      end
      start(p);
      wait_halt(64 * p.size() + 20 * UART_DIV * p.size() + 2000);
      chk($sformatf("rand%0d_checkbits", t), 32'(cb), 32'(ecb));
      chk($sformatf("rand%0d_spike", t), 32'(spk), 32'(espk));
      chk($sformatf("rand%0d_csb", t), 32'(flash_csb), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
